// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the cpu_sequencer control unit.
// Holds the state encoding, opcode constants, SelAcc and SelPC encodings,
// and the packed strobe word that ctrl_decode returns for an EXECUTE cycle.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP     = 4'b0000;
    localparam logic [3:0] OP_ADD     = 4'b0001;
    localparam logic [3:0] OP_SUB     = 4'b0010;
    localparam logic [3:0] OP_NOR     = 4'b0011;
    localparam logic [3:0] OP_LDA_REG = 4'b0100;
    localparam logic [3:0] OP_STA_REG = 4'b0101;
    localparam logic [3:0] OP_JZ_REG  = 4'b0110;
    localparam logic [3:0] OP_JZ_IMM  = 4'b0111;
    localparam logic [3:0] OP_JC_REG  = 4'b1000;
    localparam logic [3:0] OP_ILL_9   = 4'b1001;
    localparam logic [3:0] OP_JC_IMM  = 4'b1010;
    localparam logic [3:0] OP_SHL     = 4'b1011;
    localparam logic [3:0] OP_SHR     = 4'b1100;
    localparam logic [3:0] OP_LDA_IMM = 4'b1101;
    localparam logic [3:0] OP_ILL_E   = 4'b1110;
    localparam logic [3:0] OP_HALT    = 4'b1111;

    localparam logic [1:0] SEL_ACC_ALU = 2'b00;
    localparam logic [1:0] SEL_ACC_REG = 2'b01;
    localparam logic [1:0] SEL_ACC_IMM = 2'b10;

    localparam logic SEL_PC_REG = 1'b0;
    localparam logic SEL_PC_IMM = 1'b1;

    // Datapath strobes that depend on the latched instruction.
    typedef struct packed {
        logic       load_pc;
        logic       sel_pc;
        logic       load_reg;
        logic       load_acc;
        logic [1:0] sel_acc;
        logic [3:0] sel_alu;
    } exec_strb_t;

endpackage

// File: rtl/cpu_sequencer_ctrl_decode.sv
// ctrl_decode: combinational map of latched (op, z, c) to EXECUTE strobes.
// Ports: op/z/c in (latched instruction and flags); strb out (strobe word),
// illegal out (opcode has no defined behaviour). Selects are 0 unless load_acc.
module ctrl_decode
    import cpu_sequencer_pkg::*;
(
    input  logic [3:0] op,
    input  logic       z,
    input  logic       c,
    output exec_strb_t strb,
    output logic       illegal
);

    always_comb begin
        strb    = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
                strb.load_acc = 1'b1;
                strb.sel_acc  = SEL_ACC_ALU;
                strb.sel_alu  = op;
            end
            OP_LDA_REG: begin
                strb.load_acc = 1'b1;
                strb.sel_acc  = SEL_ACC_REG;
            end
            OP_LDA_IMM: begin
                strb.load_acc = 1'b1;
                strb.sel_acc  = SEL_ACC_IMM;
            end
            OP_STA_REG: strb.load_reg = 1'b1;
            OP_JZ_REG: if (z) begin
                strb.load_pc = 1'b1;
                strb.sel_pc  = SEL_PC_REG;
            end
            OP_JZ_IMM: if (z) begin
                strb.load_pc = 1'b1;
                strb.sel_pc  = SEL_PC_IMM;
            end
            OP_JC_REG: if (c) begin
                strb.load_pc = 1'b1;
                strb.sel_pc  = SEL_PC_REG;
            end
            OP_JC_IMM: if (c) begin
                strb.load_pc = 1'b1;
                strb.sel_pc  = SEL_PC_IMM;
            end
            OP_ILL_9, OP_ILL_E: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: IDLE/FETCH/DECODE/EXECUTE/HALT instruction sequencer.
// Inputs: CLK, CLB (async reset), Run, Step, Opcode, Z, C.
// Outputs: datapath strobes, Halted/Busy/StepAck/IllegalOp, State, RetiredCount.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic       CLK,
    input  logic       CLB,
    input  logic       Run,
    input  logic       Step,
    input  logic [3:0] Opcode,
    input  logic       Z,
    input  logic       C,
    output logic       LoadIR,
    output logic       IncPC,
    output logic       SelPC,
    output logic       LoadPC,
    output logic       LoadReg,
    output logic       LoadAcc,
    output logic [1:0] SelAcc,
    output logic [3:0] SelALU,
    output logic       Halted,
    output logic       Busy,
    output logic       StepAck,
    output logic       IllegalOp,
    output logic [2:0] State,
    output logic [7:0] RetiredCount
);

    localparam logic [1:0] WAIT_LAST = 2'(FETCH_WAIT);

    state_t     state;
    logic [1:0] wait_cnt;
    logic [3:0] op_q;
    logic       z_q;
    logic       c_q;
    logic       step_mode;
    logic [7:0] retired;

    exec_strb_t dec_strb;
    logic       dec_illegal;
    logic       in_exec;
    logic       fetch_last;
    logic       end_of_instr;

    ctrl_decode u_ctrl_decode (
        .op      (op_q),
        .z       (z_q),
        .c       (c_q),
        .strb    (dec_strb),
        .illegal (dec_illegal)
    );

    assign in_exec    = (state == ST_EXECUTE);
    assign fetch_last = (state == ST_FETCH) && (wait_cnt == WAIT_LAST);
    // A NOP finishes in DECODE; the decision uses the opcode being latched
    // this cycle because op_q only takes it at the closing edge.
    assign end_of_instr = in_exec ||
                          ((state == ST_DECODE) && (Opcode == OP_NOP));

    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            state     <= ST_IDLE;
            wait_cnt  <= 2'd0;
            op_q      <= 4'd0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            step_mode <= 1'b0;
            retired   <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= 2'd0;
                    if (Run) begin
                        state     <= ST_FETCH;
                        step_mode <= 1'b0;
                    end else if (Step) begin
                        state     <= ST_FETCH;
                        step_mode <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state    <= ST_DECODE;
                        wait_cnt <= 2'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_DECODE: begin
                    op_q <= Opcode;
                    z_q  <= Z;
                    c_q  <= C;
                    if (Opcode == OP_HALT) begin
                        state <= ST_HALT;
                    end else if (Opcode != OP_NOP) begin
                        state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: ;
                ST_HALT: ;
                default: state <= ST_IDLE;
            endcase

            // Instruction boundary; overrides the state chosen above.
            if (end_of_instr) begin
                retired <= retired + 8'd1;
                if (step_mode) begin
                    state     <= ST_IDLE;
                    step_mode <= 1'b0;
                end else if (Run) begin
                    state <= ST_FETCH;
                end else begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    // Outputs decode only registered state (plus the NOP boundary for
    // StepAck), so a reset clears them without waiting for a clock edge.
    assign LoadIR       = fetch_last;
    assign IncPC        = fetch_last;
    assign LoadPC       = in_exec & dec_strb.load_pc;
    assign SelPC        = in_exec & dec_strb.sel_pc;
    assign LoadReg      = in_exec & dec_strb.load_reg;
    assign LoadAcc      = in_exec & dec_strb.load_acc;
    assign SelAcc       = in_exec ? dec_strb.sel_acc : 2'b00;
    assign SelALU       = in_exec ? dec_strb.sel_alu : 4'b0000;
    assign IllegalOp    = in_exec & dec_illegal;
    assign Halted       = (state == ST_HALT);
    assign Busy         = (state != ST_IDLE) && (state != ST_HALT);
    assign StepAck      = end_of_instr & step_mode;
    assign State        = state;
    assign RetiredCount = retired;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter FETCH_WAIT, default 0, range 0..3: extra program-memory wait cycles inserted in FETCH.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 CLB  input  1  reset, asynchronous, active-high.
REQ-004 Run  input  1  level; 1 = free-run instructions continuously.
REQ-005 Step  input  1  single-step request, sampled in IDLE only.
REQ-006 Opcode  input  4  instruction register opcode field; Z input 1 ACC zero flag; C input 1 ACC carry/negative flag.
REQ-007 LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc  output  1 each  datapath strobes (SelPC: 0 = reg, 1 = imm).
REQ-008 SelAcc  output  2 (00 ALU, 01 reg, 10 imm); SelALU  output  4  ALU op code.
REQ-009 Halted  output  1; Busy  output  1 (state != IDLE/HALT); StepAck  output  1  one-cycle pulse; IllegalOp  output  1  one-cycle pulse.
REQ-010 State  output  3; RetiredCount  output  8  completed-instruction count.

Function
REQ-011 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, HALT=4; codes 5-7 SHALL recover to IDLE next cycle.
REQ-012 IDLE: all strobes 0; Run=1 -> FETCH with step_mode=0; else Step=1 -> FETCH with step_mode=1; else stay.
REQ-013 FETCH SHALL last FETCH_WAIT+1 cycles (2-bit wait counter); LoadIR=1 and IncPC=1 only in its final cycle; then DECODE.
REQ-014 DECODE: single cycle, no strobes; latch Opcode into op_q, Z into z_q, C into c_q.
REQ-015 DECODE exit: op_q=1111 -> HALT; op_q=0000 -> end-of-instruction; otherwise EXECUTE.
REQ-016 EXECUTE: single cycle; strobes decoded only from op_q/z_q/c_q, never live Opcode/Z/C; then end-of-instruction.
REQ-017 ALU ops 0001 ADD, 0010 SUB, 0011 NOR, 1011 SHL, 1100 SHR: LoadAcc=1, SelAcc=00, SelALU=op_q.
REQ-018 0100: LoadAcc=1, SelAcc=01; 1101: LoadAcc=1, SelAcc=10; 0101: LoadReg=1.
REQ-019 0110 if z_q, 0111 if z_q, 1000 if c_q, 1010 if c_q: LoadPC=1, SelPC=0/1/0/1 respectively; condition false -> no strobes.
REQ-020 Opcodes 1001, 1110: no strobes, IllegalOp=1 for the EXECUTE cycle, instruction still retires.
REQ-021 SelALU and SelAcc SHALL be 0 in every cycle where LoadAcc=0.
REQ-022 End-of-instruction: RetiredCount+1 (8-bit wrap 255->0); step_mode -> IDLE with StepAck=1 that cycle; else Run=1 -> FETCH; else IDLE.
REQ-023 Latency: FETCH_WAIT+3 cycles per executed instruction, FETCH_WAIT+2 for NOP.
REQ-024 Run deasserted mid-instruction SHALL complete that instruction, then IDLE.
REQ-025 Step outside IDLE, or with Run=1, SHALL be ignored (Run wins).
REQ-026 HALT: Halted=1, strobes 0, Run/Step ignored, exit only via CLB; HALT not counted as retired.

Reset
REQ-027 CLB=1 SHALL immediately force IDLE, all outputs 0, RetiredCount=0, wait counter/op_q/z_q/c_q/step_mode cleared, regardless of clock or state.
REQ-028 First transition after CLB release SHALL occur no earlier than the first rising CLK with CLB=0.

Structure
REQ-029 Shared package SHALL hold opcode constants, state encoding, SelAcc and SelPC encodings.
REQ-030 Combinational sub-module ctrl_decode SHALL map (op_q, z_q, c_q) to the strobe word and IllegalOp; cpu_sequencer gates it with EXECUTE.

Verification
REQ-031 FETCH_WAIT=0, Run=1, Opcode=0001 -> FETCH(LoadIR,IncPC), DECODE, EXECUTE(LoadAcc=1, SelALU=0001), FETCH; RetiredCount 0->1.
REQ-032 FETCH_WAIT=2, Opcode=0111, Z=1 -> three FETCH cycles, LoadIR only in third; EXECUTE LoadPC=1 SelPC=1; with Z=0 LoadPC stays 0.
REQ-033 Run=0, Step pulse, Opcode=0101 -> one instruction, LoadReg=1, StepAck=1 at EXECUTE, back to IDLE, Busy=0.
REQ-034 Opcode=1111 -> HALT after DECODE, Halted=1, Run/Step toggled no effect, CLB pulse -> IDLE, Halted=0.
REQ-035 Preload 255 retired instructions, retire one more -> RetiredCount=0; Opcode=1001 -> IllegalOp one-cycle pulse, no strobes.
REQ-036 CLB asserted mid-EXECUTE between clock edges -> outputs 0 and State=0 before next edge.
